// File: rtl/rst_watchdog_if.sv
// rst_watchdog_if: core-side control inputs and watchdog status outputs.
interface rst_watchdog_if #(
  parameter int CNT_W = 32
) ();
  logic             err;
  logic             commit;
  logic             restart;
  logic             core_rst;
  logic             halted;
  logic [1:0]       halt_cause;
  logic             err_seen;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] idle_count;
  modport master (
    output err, commit, restart,
    input  core_rst, halted, halt_cause, err_seen, cycle_count, idle_count
  );
  modport slave (
    input  err, commit, restart,
    output core_rst, halted, halt_cause, err_seen, cycle_count, idle_count
  );
endinterface

// File: rtl/rst_watchdog.sv
// rst_watchdog: core reset sequencer plus run watchdog with err/cycle/idle halts and restart.
module rst_watchdog #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100000,
  parameter int IDLE_LIMIT  = 0,
  parameter int HALT_ON_ERR = 1,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  rst_watchdog_if.slave wd
);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_C   = CNT_W'(IDLE_LIMIT);
  logic [1:0]       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] next_cycle, next_idle;
  logic             err_seen_q, err_seen_d;
  logic             core_rst_q, halted_q;
  logic             hit_err, hit_max, hit_idle, clear;
  always_comb begin
    next_cycle = cycle_q + ONE;
    next_idle  = wd.commit ? '0 : (&idle_q ? idle_q : idle_q + ONE);
    hit_err    = (HALT_ON_ERR != 0) && wd.err;
    hit_max    = next_cycle == MAX_C;
    hit_idle   = (IDLE_LIMIT != 0) && (next_idle == IDLE_C);
    clear      = (state_q == S_HALT) && wd.restart;
    state_d    = state_q;
    cause_d    = cause_q;
    rst_cnt_d  = rst_cnt_q;
    cycle_d    = cycle_q;
    idle_d     = idle_q;
    err_seen_d = err_seen_q;
    if (clear) begin
      state_d    = S_RESET;
      cause_d    = 2'b00;
      rst_cnt_d  = '0;
      cycle_d    = '0;
      idle_d     = '0;
      err_seen_d = 1'b0;
    end else if (state_q == S_RESET) begin
      rst_cnt_d = rst_cnt_q + ONE;
      state_d   = (rst_cnt_q == RST_LAST) ? S_RUN : S_RESET;
    end else if (state_q == S_RUN) begin
      cycle_d    = next_cycle;
      idle_d     = next_idle;
      err_seen_d = err_seen_q | wd.err;
      state_d    = (hit_err || hit_max || hit_idle) ? S_HALT : S_RUN;
      cause_d    = hit_err ? 2'b01 : hit_max ? 2'b10 : hit_idle ? 2'b11 : cause_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      cause_q    <= 2'b00;
      rst_cnt_q  <= '0;
      cycle_q    <= '0;
      idle_q     <= '0;
      err_seen_q <= 1'b0;
      core_rst_q <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rst_cnt_q  <= rst_cnt_d;
      cycle_q    <= cycle_d;
      idle_q     <= idle_d;
      err_seen_q <= err_seen_d;
      core_rst_q <= state_d == S_RESET;
      halted_q   <= state_d == S_HALT;
    end
  end
  assign wd.core_rst    = core_rst_q;
  assign wd.halted      = halted_q;
  assign wd.halt_cause  = cause_q;
  assign wd.err_seen    = err_seen_q;
  assign wd.cycle_count = cycle_q;
  assign wd.idle_count  = idle_q;
endmodule

// File: tb/tb_rst_watchdog.sv
// tb_rst_watchdog: directed checks of reset sequencing, halts, restart and reset on two configurations.
module tb_rst_watchdog;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rst_watchdog_if #(.CNT_W(32)) ia ();
  rst_watchdog_if #(.CNT_W(32)) ib ();
  rst_watchdog #(.RST_CYCLES(3), .MAX_CYCLES(10), .IDLE_LIMIT(0), .HALT_ON_ERR(1), .CNT_W(32))
    u_a (.clk(clk), .rst(rst_a), .wd(ia.slave));
  rst_watchdog #(.RST_CYCLES(2), .MAX_CYCLES(1000), .IDLE_LIMIT(4), .HALT_ON_ERR(0), .CNT_W(32))
    u_b (.clk(clk), .rst(rst_b), .wd(ib.slave));
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a_reset(input string tag);
    chk({tag, "_core_rst"}, 32'(ia.core_rst), 1);
    chk({tag, "_halted"}, 32'(ia.halted), 0);
    chk({tag, "_cause"}, 32'(ia.halt_cause), 0);
    chk({tag, "_err_seen"}, 32'(ia.err_seen), 0);
    chk({tag, "_cycle"}, ia.cycle_count, 0);
    chk({tag, "_idle"}, ia.idle_count, 0);
  endtask
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.err = 1'b0; ia.commit = 1'b0; ia.restart = 1'b0;
    ib.err = 1'b0; ib.commit = 1'b0; ib.restart = 1'b0;
    tick(3);
    chk_a_reset("a_por");
    // A: RST_CYCLES=3 release, core_rst high for three cycles
    rst_a = 1'b0; ia.commit = 1'b1;
    tick(1); chk("a_rel_e0", 32'(ia.core_rst), 1);
    tick(1); chk("a_rel_e1", 32'(ia.core_rst), 1);
    tick(1); chk("a_rel_e2", 32'(ia.core_rst), 0);
    chk("a_run_start_cycle", ia.cycle_count, 0);
    tick(1); chk("a_first_run_cycle", ia.cycle_count, 1);
    tick(3); chk("a_cycle4", ia.cycle_count, 4);
    ia.err = 1'b1; tick(1); ia.err = 1'b0;
    chk("a_err_halted", 32'(ia.halted), 1);
    chk("a_err_cause", 32'(ia.halt_cause), 1);
    chk("a_err_cycle", ia.cycle_count, 5);
    chk("a_err_seen", 32'(ia.err_seen), 1);
    tick(5);
    chk("a_err_frozen_cycle", ia.cycle_count, 5);
    chk("a_err_frozen_halted", 32'(ia.halted), 1);
    ia.restart = 1'b1; tick(1); ia.restart = 1'b0;
    chk_a_reset("a_restart");
    tick(2); chk("a_restart_core_rst_hold", 32'(ia.core_rst), 1);
    tick(1); chk("a_restart_core_rst_drop", 32'(ia.core_rst), 0);
    tick(9);
    chk("a_max_pre_cycle", ia.cycle_count, 9);
    chk("a_max_pre_halted", 32'(ia.halted), 0);
    tick(1);
    chk("a_max_halted", 32'(ia.halted), 1);
    chk("a_max_cause", 32'(ia.halt_cause), 2);
    chk("a_max_cycle", ia.cycle_count, 10);
    tick(20);
    chk("a_max_hold_cycle", ia.cycle_count, 10);
    chk("a_max_hold_cause", 32'(ia.halt_cause), 2);
    chk("a_max_hold_halted", 32'(ia.halted), 1);
    ia.restart = 1'b1; tick(1); ia.restart = 1'b0;
    tick(3); chk("a_run2_core_rst", 32'(ia.core_rst), 0);
    tick(9);
    ia.err = 1'b1; tick(1); ia.err = 1'b0;
    chk("a_errmax_cause", 32'(ia.halt_cause), 1);
    chk("a_errmax_cycle", ia.cycle_count, 10);
    chk("a_errmax_halted", 32'(ia.halted), 1);
    rst_a = 1'b1; ia.restart = 1'b1; tick(1); rst_a = 1'b0; ia.restart = 1'b0;
    chk_a_reset("a_rst_restart");
    ia.commit = 1'b0;
    tick(3); tick(7);
    chk("a_mid_cycle", ia.cycle_count, 7);
    chk("a_mid_idle", ia.idle_count, 7);
    rst_a = 1'b1; tick(1); rst_a = 1'b0;
    chk_a_reset("a_mid_rst");
    // B: RST_CYCLES=2, IDLE_LIMIT=4, err only recorded
    chk("b_por_core_rst", 32'(ib.core_rst), 1);
    rst_b = 1'b0; ib.commit = 1'b1;
    tick(1); chk("b_rel_e0", 32'(ib.core_rst), 1);
    tick(1); chk("b_rel_e1", 32'(ib.core_rst), 0);
    chk("b_run_start_cycle", ib.cycle_count, 0);
    tick(4);
    ib.err = 1'b1; tick(1); ib.err = 1'b0;
    chk("b_err_no_halt", 32'(ib.halted), 0);
    chk("b_err_seen", 32'(ib.err_seen), 1);
    chk("b_err_cycle", ib.cycle_count, 5);
    tick(1);
    chk("b_err_cont_cycle", ib.cycle_count, 6);
    chk("b_err_sticky", 32'(ib.err_seen), 1);
    ib.commit = 1'b0;
    tick(3);
    chk("b_idle3", ib.idle_count, 3);
    chk("b_idle3_halted", 32'(ib.halted), 0);
    tick(1);
    chk("b_idle_halted", 32'(ib.halted), 1);
    chk("b_idle_cause", 32'(ib.halt_cause), 3);
    chk("b_idle_count", ib.idle_count, 4);
    chk("b_idle_cycle", ib.cycle_count, 10);
    ib.err = 1'b1; ib.commit = 1'b1; tick(2); ib.err = 1'b0;
    chk("b_halt_ign_idle", ib.idle_count, 4);
    chk("b_halt_ign_cycle", ib.cycle_count, 10);
    rst_b = 1'b1; tick(1); rst_b = 1'b0;
    chk("b_rst_err_seen", 32'(ib.err_seen), 0);
    tick(2);
    chk("b_run2_core_rst", 32'(ib.core_rst), 0);
    chk("b_run2_cycle", ib.cycle_count, 0);
    for (int i = 0; i < 40; i++) begin
      ib.commit = (i % 4 == 3);
      tick(1);
    end
    chk("b_sparse_halted", 32'(ib.halted), 0);
    chk("b_sparse_cycle", ib.cycle_count, 40);
    chk("b_sparse_idle", ib.idle_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
